fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard unit for the scalar/vector pipeline. It sits between the EX stage operand muxes and the MEM/WB pipeline registers, and serves NUM_SRC source operands.
- Selects the newest in-flight result for each source operand.
- Stalls EX while a load occupies MEM for a variable number of cycles.
- Captures WB-stage results that would otherwise be lost while EX is held by an external stall.

---
 rtl/fwd_pkg.sv | 15 +
 rtl/fwd_operand_sel.sv | 85 ++++++++
 rtl/fwd_hazard_unit.sv | 115 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and default widths for the forwarding/hazard unit.
// Contents:
//   fwd_state_e  load-stall FSM state
//   fwd_src_e    per-operand forwarding source
//   *_D          default parameter values used by the top level
package fwd_pkg;
  typedef enum logic {IDLE, LOAD_WAIT} fwd_state_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_MEM, SRC_WB, SRC_HELD} fwd_src_e;

  localparam int NUM_SRC_D = 2;
  localparam int NREGS_D   = 32;
  localparam int XLEN_D    = 32;
  localparam int VLEN_D    = 256;
  localparam int STAT_W_D  = 32;
endpackage

// File: rtl/fwd_operand_sel.sv
// One source operand: priority compare (MEM > WB > HELD), data mux and the
// single-entry hold buffer that keeps a WB result alive while EX is held.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   rs                                 source register index
//   we_mem, wb_sel_mem, rd_mem         MEM writer (only ALU results forward)
//   result_mem, result_wb              stage results
//   we_wb, rd_wb                       WB writer
//   cap_win                            EX is held with a real instruction
//   ex_adv                             EX advances this cycle (releases entry)
//   flush                              sync clear of the entry
//   sel, data                          forward enable and selected value
module fwd_operand_sel
  import fwd_pkg::*;
#(
  parameter int RIDX = 5,
  parameter int VLEN = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RIDX-1:0] rs,
  input  logic            we_mem,
  input  logic            wb_sel_mem,
  input  logic [RIDX-1:0] rd_mem,
  input  logic [VLEN-1:0] result_mem,
  input  logic            we_wb,
  input  logic [RIDX-1:0] rd_wb,
  input  logic [VLEN-1:0] result_wb,
  input  logic            cap_win,
  input  logic            ex_adv,
  input  logic            flush,
  output logic            sel,
  output logic [VLEN-1:0] data
);
  logic            held_valid_q, held_valid_d;
  logic [RIDX-1:0] held_idx_q, held_idx_d;
  logic [VLEN-1:0] held_data_q, held_data_d;
  fwd_src_e        src;

  // Writers to r0 never match, so rs==0 can never forward.
  always_comb begin
    src = SRC_NONE;
    if (we_mem && wb_sel_mem && rd_mem != '0 && rd_mem == rs) src = SRC_MEM;
    else if (we_wb && rd_wb != '0 && rd_wb == rs)             src = SRC_WB;
    else if (held_valid_q && held_idx_q == rs)                src = SRC_HELD;
  end

  always_comb begin
    data = '0;
    case (src)
      SRC_MEM:  data = result_mem;
      SRC_WB:   data = result_wb;
      SRC_HELD: data = held_data_q;
      default:  data = '0;
    endcase
  end

  assign sel = (src != SRC_NONE);

  // Release beats capture; capture and advance are mutually exclusive anyway.
  always_comb begin
    held_valid_d = held_valid_q;
    held_idx_d   = held_idx_q;
    held_data_d  = held_data_q;
    if (flush || ex_adv) begin
      held_valid_d = 1'b0;
    end else if (cap_win && src == SRC_WB) begin
      held_valid_d = 1'b1;
      held_idx_d   = rs;
      held_data_d  = result_wb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid_q <= 1'b0;
      held_idx_q   <= '0;
      held_data_q  <= '0;
    end else begin
      held_valid_q <= held_valid_d;
      held_idx_q   <= held_idx_d;
      held_data_q  <= held_data_d;
    end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for NUM_SRC EX source operands.
// Forward selection and stall are combinational (Mealy) from the inputs and
// registered state. Optional perf counters are built when FWD_PERF_EN is
// defined (adds parameter STAT_W and ports stall_cycles, fwd_count).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ex_valid, ext_stall, flush EX occupancy, external hold, sync flush
//   rs_ex                      EX source indices
//   we_mem, wb_sel_mem, rd_mem MEM writer (wb_sel_mem=0 means load)
//   mem_ready                  load data returns this cycle
//   result_mem, result_wb      stage results
//   we_wb, rd_wb               WB writer
//   stall                      hold IF/ID/EX, bubble into MEM
//   fwd_sel, fwd_scalar, fwd_vector  per-source forward enable and data
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_D,
  parameter int NREGS   = NREGS_D,
  parameter int XLEN    = XLEN_D,
  parameter int VLEN    = VLEN_D,
`ifdef FWD_PERF_EN
  parameter int STAT_W  = STAT_W_D,
`endif
  localparam int RIDX   = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ex_valid,
  input  logic                          ext_stall,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0][RIDX-1:0]  rs_ex,
  input  logic                          we_mem,
  input  logic                          wb_sel_mem,
  input  logic [RIDX-1:0]               rd_mem,
  input  logic                          mem_ready,
  input  logic [VLEN-1:0]               result_mem,
  input  logic [VLEN-1:0]               result_wb,
  input  logic                          we_wb,
  input  logic [RIDX-1:0]               rd_wb,
  output logic                          stall,
  output logic [NUM_SRC-1:0]            fwd_sel,
  output logic [NUM_SRC-1:0][XLEN-1:0]  fwd_scalar,
  output logic [NUM_SRC-1:0][VLEN-1:0]  fwd_vector
`ifdef FWD_PERF_EN
  ,
  output logic [STAT_W-1:0]             stall_cycles,
  output logic [STAT_W-1:0]             fwd_count
`endif
);
  fwd_state_e         state_q;
  logic [NUM_SRC-1:0] rs_hit;
  logic               load_hazard, cap_win, ex_adv;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign rs_hit[i] = (rd_mem == rs_ex[i]);

    fwd_operand_sel #(.RIDX(RIDX), .VLEN(VLEN)) u_sel (
      .clk        (clk),
      .rst_n      (rst_n),
      .rs         (rs_ex[i]),
      .we_mem     (we_mem),
      .wb_sel_mem (wb_sel_mem),
      .rd_mem     (rd_mem),
      .result_mem (result_mem),
      .we_wb      (we_wb),
      .rd_wb      (rd_wb),
      .result_wb  (result_wb),
      .cap_win    (cap_win),
      .ex_adv     (ex_adv),
      .flush      (flush),
      .sel        (fwd_sel[i]),
      .data       (fwd_vector[i])
    );

    assign fwd_scalar[i] = fwd_vector[i][XLEN-1:0];
  end

  assign load_hazard = ex_valid && we_mem && !wb_sel_mem && rd_mem != '0 && |rs_hit;
  assign stall       = (state_q == LOAD_WAIT) || load_hazard;
  assign cap_win     = (stall || ext_stall) && ex_valid;
  assign ex_adv      = ex_valid && !stall && !ext_stall;

  // With mem_ready alongside the hazard the single stall cycle suffices:
  // the load reaches WB next cycle and forwards from there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state_q <= IDLE;
    else if (flush) state_q <= IDLE;
    else begin
      case (state_q)
        IDLE:      if (load_hazard && !mem_ready) state_q <= LOAD_WAIT;
        LOAD_WAIT: if (mem_ready)                 state_q <= IDLE;
        default:                                  state_q <= IDLE;
      endcase
    end
  end

`ifdef FWD_PERF_EN
  logic [STAT_W-1:0] stall_cycles_q, fwd_count_q;

  // Saturating counters, cleared only by reset (not by flush).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      fwd_count_q    <= '0;
    end else begin
      if (stall && !(&stall_cycles_q))  stall_cycles_q <= stall_cycles_q + 1'b1;
      if (|fwd_sel && !(&fwd_count_q))  fwd_count_q    <= fwd_count_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_count    = fwd_count_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
  localparam int NUM_SRC = 2;
  localparam int RIDX    = 5;
  localparam int XLEN    = 32;
  localparam int VLEN    = 256;
  localparam int STAT_W  = 4;

  logic                         clk, rst_n;
  logic                         ex_valid, ext_stall, flush;
  logic [NUM_SRC-1:0][RIDX-1:0] rs_ex;
  logic                         we_mem, wb_sel_mem, mem_ready, we_wb;
  logic [RIDX-1:0]              rd_mem, rd_wb;
  logic [VLEN-1:0]              result_mem, result_wb;
  logic                         stall;
  logic [NUM_SRC-1:0]           fwd_sel;
  logic [NUM_SRC-1:0][XLEN-1:0] fwd_scalar;
  logic [NUM_SRC-1:0][VLEN-1:0] fwd_vector;
`ifdef FWD_PERF_EN
  logic [STAT_W-1:0]            stall_cycles, fwd_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [VLEN-1:0] big;

  fwd_hazard_unit #(
    .NUM_SRC(NUM_SRC), .NREGS(32), .XLEN(XLEN), .VLEN(VLEN)
`ifdef FWD_PERF_EN
    , .STAT_W(STAT_W)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ext_stall(ext_stall),
    .flush(flush), .rs_ex(rs_ex), .we_mem(we_mem), .wb_sel_mem(wb_sel_mem),
    .rd_mem(rd_mem), .mem_ready(mem_ready), .result_mem(result_mem),
    .result_wb(result_wb), .we_wb(we_wb), .rd_wb(rd_wb), .stall(stall),
    .fwd_sel(fwd_sel), .fwd_scalar(fwd_scalar), .fwd_vector(fwd_vector)
`ifdef FWD_PERF_EN
    , .stall_cycles(stall_cycles), .fwd_count(fwd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ex_valid = 0; ext_stall = 0; flush = 0; rs_ex = '0;
    we_mem = 0; wb_sel_mem = 0; rd_mem = '0; mem_ready = 0; result_mem = '0;
    we_wb = 0; rd_wb = '0; result_wb = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; idle();
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_sel", fwd_sel, 0);
    chk("rst_vec0", fwd_vector[0], 0);
`ifdef FWD_PERF_EN
    chk("rst_cnt", stall_cycles, 0);
`endif
    @(negedge clk); rst_n = 1; step();

    // ALU RAW on both sources: MEM beats WB
    big = 256'h1 << 200;
    ex_valid = 1; rs_ex[0] = 5'd3; rs_ex[1] = 5'd3;
    we_mem = 1; wb_sel_mem = 1; rd_mem = 5'd3; result_mem = big | 256'hAA;
    we_wb = 1; rd_wb = 5'd3; result_wb = 256'hBB;
    @(negedge clk);
    chk("raw_sel", fwd_sel, 2'b11);
    chk("raw_s0", fwd_scalar[0], 32'hAA);
    chk("raw_s1", fwd_scalar[1], 32'hAA);
    chk("raw_v1", fwd_vector[1], big | 256'hAA);
    chk("raw_stall", stall, 0);
    step();

    // x0 never matches; source 1 from WB
    idle(); ex_valid = 1; rs_ex[0] = 5'd0; rs_ex[1] = 5'd4;
    we_mem = 1; wb_sel_mem = 1; rd_mem = 5'd0; result_mem = 256'h55;
    we_wb = 1; rd_wb = 5'd4; result_wb = 256'h44;
    @(negedge clk);
    chk("x0_sel", fwd_sel, 2'b10);
    chk("x0_s0", fwd_scalar[0], 0);
    chk("x0_s1", fwd_scalar[1], 32'h44);
    step();
    idle(); ex_valid = 1; we_mem = 1; wb_sel_mem = 0; rd_mem = 5'd0;
    @(negedge clk);
    chk("x0_load_nostall", stall, 0);
    step();

    // load-use, data 3 cycles late: 4 stall cycles
    idle(); ex_valid = 1; rs_ex[0] = 5'd1; rs_ex[1] = 5'd5;
    we_mem = 1; wb_sel_mem = 0; rd_mem = 5'd5;
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 3);
      @(negedge clk);
      chk($sformatf("lu_stall%0d", c), stall, 1);
      chk($sformatf("lu_sel%0d", c), fwd_sel, 0);
      step();
    end
    we_mem = 0; mem_ready = 0; we_wb = 1; rd_wb = 5'd5; result_wb = 256'h777;
    @(negedge clk);
    chk("lu_rel_stall", stall, 0);
    chk("lu_rel_sel", fwd_sel, 2'b10);
    chk("lu_rel_s1", fwd_scalar[1], 32'h777);
    step();

    // load-use with data ready immediately: 1 stall cycle
    idle(); ex_valid = 1; rs_ex[0] = 5'd5;
    we_mem = 1; wb_sel_mem = 0; rd_mem = 5'd5; mem_ready = 1;
    @(negedge clk);
    chk("lu1_stall", stall, 1);
    step();
    we_mem = 0; mem_ready = 0; we_wb = 1; rd_wb = 5'd5; result_wb = 256'h999;
    @(negedge clk);
    chk("lu1_rel_stall", stall, 0);
    chk("lu1_rel_s0", fwd_scalar[0], 32'h999);
    step();

    // hold capture under ext_stall, overwrite, release on advance
    idle(); ex_valid = 1; ext_stall = 1; rs_ex[0] = 5'd7; rs_ex[1] = 5'd2;
    we_wb = 1; rd_wb = 5'd7; result_wb = 256'h1234;
    @(negedge clk); chk("hold_a", fwd_scalar[0], 32'h1234); step();
    rd_wb = 5'd9; result_wb = 256'h9999;
    @(negedge clk);
    chk("hold_b_sel", fwd_sel, 2'b01);
    chk("hold_b", fwd_scalar[0], 32'h1234);
    step();
    rd_wb = 5'd7; result_wb = 256'h5678;
    @(negedge clk); chk("hold_c_wb", fwd_scalar[0], 32'h5678); step();
    rd_wb = 5'd9; result_wb = 256'h9999; ext_stall = 0;
    @(negedge clk); chk("hold_d_ovw", fwd_scalar[0], 32'h5678); step();
    @(negedge clk); chk("hold_e_clr", fwd_sel, 0); step();

    // flush in LOAD_WAIT; flush beats coincident capture
    idle(); ex_valid = 1; rs_ex[0] = 5'd6; rs_ex[1] = 5'd8;
    we_mem = 1; wb_sel_mem = 0; rd_mem = 5'd6;
    we_wb = 1; rd_wb = 5'd8; result_wb = 256'hCC;
    @(negedge clk); chk("fl0_stall", stall, 1); chk("fl0_s1", fwd_scalar[1], 32'hCC); step();
    we_wb = 0;
    @(negedge clk);
    chk("fl1_stall", stall, 1);
    chk("fl1_sel", fwd_sel, 2'b10);
    chk("fl1_held", fwd_scalar[1], 32'hCC);
    step();
    flush = 1; we_wb = 1; result_wb = 256'hDD;
    @(negedge clk); chk("fl2_s1", fwd_scalar[1], 32'hDD); step();
    flush = 0; ex_valid = 0; we_mem = 0; we_wb = 0;
    @(negedge clk);
    chk("fl3_stall", stall, 0);
    chk("fl3_sel", fwd_sel, 0);
    step();

    // async reset mid-operation
    idle(); ex_valid = 1; rs_ex[0] = 5'd6; rs_ex[1] = 5'd8;
    we_mem = 1; wb_sel_mem = 0; rd_mem = 5'd6;
    we_wb = 1; rd_wb = 5'd8; result_wb = 256'hEE;
    step();
    ex_valid = 0; we_mem = 0; we_wb = 0;
    @(negedge clk);
    chk("ar_pre_stall", stall, 1);
    chk("ar_pre_s1", fwd_scalar[1], 32'hEE);
    #2 rst_n = 0;
    #1;
    chk("ar_stall", stall, 0);
    chk("ar_sel", fwd_sel, 0);
    chk("ar_v1", fwd_vector[1], 0);
`ifdef FWD_PERF_EN
    chk("ar_cnt_s", stall_cycles, 0);
    chk("ar_cnt_f", fwd_count, 0);
`endif
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("ar_post_stall", stall, 0); step();

    // counters: 5 stall cycles, 3 forwarding cycles
    idle(); ex_valid = 1; rs_ex[0] = 5'd1; rs_ex[1] = 5'd5;
    we_mem = 1; wb_sel_mem = 0; rd_mem = 5'd5;
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c == 4);
      @(negedge clk); chk($sformatf("pc_stall%0d", c), stall, 1); step();
    end
    mem_ready = 0; we_mem = 0; we_wb = 1; rd_wb = 5'd5; result_wb = 256'h11;
    @(negedge clk); chk("pc_fwd_wb", fwd_sel, 2'b10); step();
    we_wb = 0; we_mem = 1; wb_sel_mem = 1; rd_mem = 5'd1; result_mem = 256'h22;
    step(); step();
    idle();
    @(negedge clk);
`ifdef FWD_PERF_EN
    chk("pc_stall_cnt", stall_cycles, 5);
    chk("pc_fwd_cnt", fwd_count, 3);
`endif
    step();

    // saturate stall counter (5 + 12 > 15)
    ex_valid = 1; rs_ex[0] = 5'd5; we_mem = 1; wb_sel_mem = 0; rd_mem = 5'd5;
    for (int c = 0; c < 12; c++) step();
    idle();
    @(negedge clk);
    chk("sat_stall_held", stall, 1);
`ifdef FWD_PERF_EN
    chk("sat_stall_cnt", stall_cycles, 4'hF);
    chk("sat_fwd_cnt", fwd_count, 3);
`endif
    mem_ready = 1; step();
    mem_ready = 0; step();
`ifdef FWD_PERF_EN
    chk("sat_stays", stall_cycles, 4'hF);
`endif
    chk("end_stall", stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
